// File: rtl/pokey_pkg.sv
// Shared definitions for the POKEY audio channel blocks.
// Holds the channel FSM state encoding and the default widths/timing constants.
package pokey_pkg;

  // Channel divider FSM: counting down, or padding the reload in fast mode.
  typedef enum logic {
    COUNT = 1'b0,
    WAIT  = 1'b1
  } chan_state_t;

  // Extra reload ticks inserted per underflow when clocked at 1.79 MHz.
  localparam int POKEY_FAST_EXTRA = 3;

  // AUDF register / channel counter width.
  localparam int POKEY_AUDF_W = 8;

endpackage

// File: rtl/pokey_channel_counter.sv
// One POKEY audio channel divider: an 8-bit down counter reloaded from a local
// AUDF register, emitting an underflow pulse and a square-wave tone bit.
// Optional build macro POKEY_CHAN_LINK_EN adds link_in/link_mode so this
// channel can act as the high byte of a 16-bit joined channel.
//
// Handshake: there is no valid/ready pair here. Every register update is
// qualified by ce; a count tick is ce & enable_in (or ce & link_in when linked),
// syncreset and audf_wr are single-ce strobes sampled on ce edges only.
module pokey_channel_counter
  import pokey_pkg::*;
#(
  parameter int WIDTH      = POKEY_AUDF_W,
  parameter int FAST_EXTRA = POKEY_FAST_EXTRA
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             enable_in,
  input  logic             syncreset,
  input  logic             fast_mode,
  input  logic             audf_wr,
  input  logic [WIDTH-1:0] audf_din,
`ifdef POKEY_CHAN_LINK_EN
  input  logic             link_in,
  input  logic             link_mode,
`endif
  output logic             underflow_out,
  output logic             tone_out,
  output logic [WIDTH-1:0] count_out
);

  // Wait counter only has to hold FAST_EXTRA-1.
  localparam int WAIT_W = (FAST_EXTRA > 1) ? $clog2(FAST_EXTRA) : 1;

  chan_state_t       r_state;
  chan_state_t       w_state_nx;
  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  w_count_nx;
  logic [WIDTH-1:0]  r_audf;
  logic [WIDTH-1:0]  w_audf_nx;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nx;
  logic              r_underflow;
  logic              w_underflow_nx;
  logic              r_tone;
  logic              w_tone_nx;

  logic              w_tick;
  logic              w_fast;
  logic              w_count_zero;
  logic              w_wait_zero;

  // A write on the same edge as a reload is seen by that reload.
  assign w_audf_nx = audf_wr ? audf_din : r_audf;

`ifdef POKEY_CHAN_LINK_EN
  // Linked high byte counts the lower channel's underflows and never pads.
  assign w_tick = ce & (link_mode ? link_in : enable_in);
  assign w_fast = fast_mode & ~link_mode;
`else
  assign w_tick = ce & enable_in;
  assign w_fast = fast_mode;
`endif

  assign w_count_zero = (r_count == '0);
  assign w_wait_zero  = (r_wait == '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= COUNT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic: syncreset forces COUNT, fast underflow enters WAIT.
  always_comb begin
    w_state_nx = r_state;
    if (ce && syncreset) begin
      w_state_nx = COUNT;
    end else if (w_tick) begin
      case (r_state)
        COUNT:   if (w_count_zero && w_fast) w_state_nx = WAIT;
        WAIT:    if (w_wait_zero) w_state_nx = COUNT;
        default: w_state_nx = COUNT;
      endcase
    end
  end

  // Output/datapath logic: counter, wait counter, underflow pulse, tone.
  always_comb begin
    w_count_nx     = r_count;
    w_wait_nx      = r_wait;
    w_underflow_nx = r_underflow;
    w_tone_nx      = r_tone;
    if (ce) begin
      // The pulse lasts one ce period unless re-armed below.
      w_underflow_nx = 1'b0;
      if (syncreset) begin
        w_count_nx = w_audf_nx;
        w_wait_nx  = '0;
        w_tone_nx  = 1'b0;
      end else if (w_tick) begin
        case (r_state)
          COUNT: begin
            if (!w_count_zero) begin
              w_count_nx = r_count - WIDTH'(1);
            end else begin
              w_underflow_nx = 1'b1;
              w_tone_nx      = ~r_tone;
              if (w_fast) begin
                w_wait_nx = WAIT_W'(FAST_EXTRA - 1);
              end else begin
                w_count_nx = w_audf_nx;
              end
            end
          end
          WAIT: begin
            if (w_wait_zero) begin
              w_count_nx = w_audf_nx;
            end else begin
              w_wait_nx = r_wait - WAIT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath registers; AUDF follows every ce edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_audf      <= '0;
      r_wait      <= '0;
      r_underflow <= 1'b0;
      r_tone      <= 1'b0;
    end else begin
      r_count     <= w_count_nx;
      r_wait      <= w_wait_nx;
      r_underflow <= w_underflow_nx;
      r_tone      <= w_tone_nx;
      if (ce) begin
        r_audf <= w_audf_nx;
      end
    end
  end

  assign underflow_out = r_underflow;
  assign tone_out      = r_tone;
  assign count_out     = r_count;

endmodule

// File: tb/tb_pokey_channel_counter.sv
// Directed testbench for pokey_channel_counter (default build, 8-bit, FAST_EXTRA=3).
module tb_pokey_channel_counter;

  logic       clk;
  logic       reset_n;
  logic       ce;
  logic       enable_in;
  logic       syncreset;
  logic       fast_mode;
  logic       audf_wr;
  logic [7:0] audf_din;
  logic       underflow_out;
  logic       tone_out;
  logic [7:0] count_out;
`ifdef POKEY_CHAN_LINK_EN
  logic       link_in;
  logic       link_mode;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Clock/reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pokey_channel_counter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce            (ce),
    .enable_in     (enable_in),
    .syncreset     (syncreset),
    .fast_mode     (fast_mode),
    .audf_wr       (audf_wr),
    .audf_din      (audf_din),
`ifdef POKEY_CHAN_LINK_EN
    .link_in       (link_in),
    .link_mode     (link_mode),
`endif
    .underflow_out (underflow_out),
    .tone_out      (tone_out),
    .count_out     (count_out)
  );

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic u, input logic t);
    check({tag, ".count"}, 32'(count_out), 32'(c));
    check({tag, ".uf"}, 32'(underflow_out), 32'(u));
    check({tag, ".tone"}, 32'(tone_out), 32'(t));
  endtask

  // Hand-computed tables.
  logic [7:0] p1_cnt [8] = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
  logic       p1_uf  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       p1_tn  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] p2_cnt [14] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3,
                              8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3};
  logic       p2_uf  [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       p2_tn  [14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] p6_cnt [7] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd2};

  initial begin
    reset_n   = 1'b0;
    ce        = 1'b1;
    enable_in = 1'b0;
    syncreset = 1'b0;
    fast_mode = 1'b0;
    audf_wr   = 1'b0;
    audf_din  = 8'd0;
`ifdef POKEY_CHAN_LINK_EN
    link_in   = 1'b0;
    link_mode = 1'b0;
`endif

    // Reset values.
    step();
    step();
    check_all("reset", 8'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    // Normal mode, AUDF=3, tick every 4th ce.
    audf_wr = 1'b1; audf_din = 8'd3; syncreset = 1'b1;
    step();
    audf_wr = 1'b0; syncreset = 1'b0;
    check_all("load3", 8'd3, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      enable_in = 1'b1;
      step();
      enable_in = 1'b0;
      check_all($sformatf("norm%0d", k), p1_cnt[k], p1_uf[k], p1_tn[k]);
      step();
      check($sformatf("norm%0d.ufclr", k), 32'(underflow_out), 32'd0);
      step();
      step();
    end

    // Fast mode, AUDF=3, tick every ce: period 7.
    fast_mode = 1'b1; enable_in = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      check_all($sformatf("fast%0d", k), p2_cnt[k], p2_uf[k], p2_tn[k]);
    end

    // Reset asserted while in WAIT.
    for (int k = 0; k < 4; k++) step();
    check_all("prewait", 8'd0, 1'b1, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_all("rstwait", 8'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    fast_mode = 1'b0;

    // Back in COUNT at 0: tick underflows, same-edge write is used by reload.
    audf_wr = 1'b1; audf_din = 8'd2; enable_in = 1'b1;
    step();
    check_all("bypass", 8'd2, 1'b1, 1'b1);

    // AUDF=0 back-to-back underflows.
    audf_din = 8'd0; enable_in = 1'b0;
    step();
    audf_wr = 1'b0;
    check_all("audf0wr", 8'd2, 1'b0, 1'b1);
    enable_in = 1'b1;
    step();
    step();
    check_all("a0pre", 8'd0, 1'b0, 1'b1);
    step();
    check_all("a0_c3", 8'd0, 1'b1, 1'b0);
    step();
    check_all("a0_c4", 8'd0, 1'b1, 1'b1);
    step();
    check_all("a0_c5", 8'd0, 1'b1, 1'b0);
    step();
    check_all("a0_c6", 8'd0, 1'b1, 1'b1);

    // Syncreset coincident with a tick at count 0 wins over the underflow.
    enable_in = 1'b0; audf_wr = 1'b1; audf_din = 8'd9;
    step();
    audf_wr = 1'b0;
    check_all("w9", 8'd0, 1'b0, 1'b1);
    syncreset = 1'b1; enable_in = 1'b1;
    step();
    syncreset = 1'b0;
    check_all("srtick", 8'd9, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    enable_in = 1'b0;
    check_all("mid5", 8'd5, 1'b0, 1'b0);
    syncreset = 1'b1;
    step();
    syncreset = 1'b0;
    check_all("sr5", 8'd9, 1'b0, 1'b0);

    // AUDF write 9->2 while counting does not disturb the running count.
    enable_in = 1'b1;
    for (int k = 0; k < 3; k++) step();
    enable_in = 1'b0;
    check("at6", 32'(count_out), 32'd6);
    audf_wr = 1'b1; audf_din = 8'd2;
    step();
    audf_wr = 1'b0;
    check("wr2hold", 32'(count_out), 32'd6);
    enable_in = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("run%0d", k), 32'(count_out), 32'(p6_cnt[k]));
    end
    check("run.uf", 32'(underflow_out), 32'd1);
    check("run.tone", 32'(tone_out), 32'd1);

    // ce=0 freezes everything, including syncreset and AUDF writes.
    ce = 1'b0; syncreset = 1'b1; audf_wr = 1'b1; audf_din = 8'd7; fast_mode = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check_all("frozen", 8'd2, 1'b1, 1'b1);
    ce = 1'b1; syncreset = 1'b0; audf_wr = 1'b0; fast_mode = 1'b0;
    step();
    check_all("thaw1", 8'd1, 1'b0, 1'b1);
    step();
    step();
    check_all("thaw_rl", 8'd2, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
